if_fetch_queue: RTL and testbench

- Instruction fetch stage sitting directly downstream of the PC stage.
- Takes the current PC, issues in-order read requests to instruction memory over a req/gnt + rvalid interface, and tracks in-flight requests.
- Buffers returned words with their PCs in a small queue that feeds decode through a valid/ready handshake.
- On a control-flow redirect it flushes queued and in-flight fetches and tells the PC stage when it may advance.

---
 rtl/if_fetch_queue.sv | 147 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: issues in-order reads to instruction memory,
// tracks the PCs of in-flight requests, and buffers returned words with
// their PCs in a small queue that feeds decode. A redirect (Flush) empties
// the queue and marks every in-flight request to be discarded on return.
module if_fetch_queue #(
  parameter int D_WIDTH         = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] PC,
  output logic               PCAdvance,
  input  logic               Flush,
  output logic               imem_req,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               InstrValid,
  output logic [31:0]        Instr,
  output logic [D_WIDTH-1:0] InstrPC,
  input  logic               InstrReady
);

  localparam int QAW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [OW-1:0]  MAX_O   = OW'(MAX_OUTSTANDING);
  localparam logic [IAW-1:0] IF_LAST = IAW'(MAX_OUTSTANDING - 1);

  // In-flight PC FIFO (one slot per accepted, unreturned request)
  logic [D_WIDTH-1:0] r_if_pc [MAX_OUTSTANDING];
  logic [IAW-1:0]     r_if_wptr;
  logic [IAW-1:0]     r_if_rptr;
  logic [OW-1:0]      r_out;
  logic [OW-1:0]      r_drop;

  // Output queue of {PC, instruction}
  logic [D_WIDTH-1:0] r_q_pc  [DEPTH];
  logic [31:0]        r_q_ins [DEPTH];
  logic [QAW-1:0]     r_q_wptr;
  logic [QAW-1:0]     r_q_rptr;
  logic [CW-1:0]      r_q_cnt;

  logic        w_accept;
  logic        w_resp;
  logic        w_discard;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_credit_used;

  // The in-flight FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [IAW-1:0] if_next(input logic [IAW-1:0] ptr);
    return (ptr == IF_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // Dropped in-flight entries still consume credit: conservative, but it
  // guarantees every word that does get pushed has a free queue slot.
  assign w_credit_used = 32'(r_out) + 32'(r_q_cnt);

  // NOTE: rst gates the request combinationally so that an asynchronous
  // reset silences the memory interface immediately, not at the next edge.
  assign imem_req  = !rst && !Flush && (r_out < MAX_O) && (w_credit_used < 32'(DEPTH));
  assign imem_addr = PC;
  assign w_accept  = imem_req && imem_gnt;
  assign PCAdvance = w_accept;

  assign w_resp    = imem_rvalid && (r_out != '0);
  assign w_discard = (r_drop != '0) || Flush;
  assign w_push    = w_resp && !w_discard;

  assign InstrValid = (r_q_cnt != '0);
  assign w_pop      = InstrValid && InstrReady && !Flush;

  // Head is masked when empty so the outputs read 0 out of reset.
  assign Instr   = InstrValid ? r_q_ins[r_q_rptr] : '0;
  assign InstrPC = InstrValid ? r_q_pc[r_q_rptr]  : '0;

  // In-flight bookkeeping: pointers, outstanding count and drop count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_if_wptr <= '0;
      r_if_rptr <= '0;
      r_out     <= '0;
      r_drop    <= '0;
    end else begin
      if (w_accept) r_if_wptr <= if_next(r_if_wptr);
      if (w_resp)   r_if_rptr <= if_next(r_if_rptr);

      case ({w_accept, w_resp})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase

      // Everything still in flight after this cycle belongs to the old path.
      if (Flush) begin
        r_drop <= r_out - OW'(w_resp);
      end else if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - 1'b1;
      end
    end
  end

  // Output queue control: pointers and occupancy.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_q_wptr <= '0;
      r_q_rptr <= '0;
      r_q_cnt  <= '0;
    end else if (Flush) begin
      r_q_wptr <= '0;
      r_q_rptr <= '0;
      r_q_cnt  <= '0;
    end else begin
      if (w_push) r_q_wptr <= r_q_wptr + 1'b1;
      if (w_pop)  r_q_rptr <= r_q_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
        2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  // Storage arrays: PCs of accepted requests and returned {PC, word} pairs.
  // NOTE: storage is left unreset; validity is carried entirely by the
  // counters and pointers, so reset-free RAM cells are safe here.
  always_ff @(posedge CLK) begin
    if (w_accept) r_if_pc[r_if_wptr] <= PC;
    if (w_push) begin
      r_q_pc[r_q_wptr]  <= r_if_pc[r_if_rptr];
      r_q_ins[r_q_wptr] <= imem_rdata;
    end
  end

  // A response with nothing in flight violates the memory protocol; the RTL
  // ignores it, simulation flags it.
  a_no_stray_rvalid: assert property (@(posedge CLK) disable iff (rst)
    !(imem_rvalid && (r_out == '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: a latency-programmable in-order
// memory model plus a scoreboard of expected {PC, word} pairs, pushed when a
// request is accepted and popped when decode consumes the queue head.
module tb_if_fetch_queue;

  localparam int DW      = 32;
  localparam int MAX_OUT = 2;

  logic          CLK;
  logic          rst;
  logic [DW-1:0] PC;
  logic          PCAdvance;
  logic          Flush;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          InstrValid;
  logic [31:0]   Instr;
  logic [DW-1:0] InstrPC;
  logic          InstrReady;

  if_fetch_queue #(.D_WIDTH(DW), .DEPTH(4), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .PC          (PC),
    .PCAdvance   (PCAdvance),
    .Flush       (Flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrValid  (InstrValid),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrReady  (InstrReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mrsp_t;

  typedef struct {
    logic [DW-1:0] pc;
    logic [31:0]   ins;
  } exp_t;

  mrsp_t mem_q[$];
  exp_t  exp_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          lat;
  int          adv_cnt;
  int          first_acc;
  int          first_valid;
  bit          gnt_en;
  bit          flush_on_rv;
  bit          prev_flush;
  bit          check_sat;
  bit          sat_seen;
  bit          want_first;
  logic [31:0] first_pc;
  logic [31:0] pc_reg;
  logic [31:0] flush_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // One clock cycle: drive inputs at the falling edge, sample 1ns later.
  task automatic step(input bit flush, input bit ready);
    bit    rv;
    bit    fl;
    exp_t  e;
    mrsp_t m;
    PC         = pc_reg;
    InstrReady = ready;
    imem_gnt   = gnt_en;
    rv         = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_q[0].data : 32'h0;
    fl = flush || (flush_on_rv && rv);
    if (fl) flush_on_rv = 1'b0;
    Flush = fl;
    #1;
    if (prev_flush) check("valid_after_flush", InstrValid, 1'b0);
    prev_flush = fl;
    if (fl) check("flush_blocks_req", imem_req, 1'b0);
    if (mem_q.size() == MAX_OUT) begin
      sat_seen = 1'b1;
      if (check_sat) check("sat_no_adv", PCAdvance, 1'b0);
    end
    check("pcadv_eq_accept", PCAdvance, imem_req && imem_gnt);
    if (imem_req) check("imem_addr", imem_addr, pc_reg);
    if (InstrValid && ready && !fl) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", InstrValid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", InstrPC, e.pc);
        check("instr", Instr, e.ins);
        if (want_first) begin
          first_pc   = InstrPC;
          want_first = 1'b0;
        end
      end
    end
    if (imem_req && imem_gnt) begin
      m.due  = cyc + lat;
      m.data = data_of(pc_reg);
      mem_q.push_back(m);
      e.pc  = pc_reg;
      e.ins = m.data;
      exp_q.push_back(e);
      adv_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (PCAdvance) pc_reg = pc_reg + 32'd4;
    if (first_valid < 0 && InstrValid) first_valid = cyc;
    if (rv) void'(mem_q.pop_front());
    if (fl) begin
      exp_q.delete();
      pc_reg = flush_pc;
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic reset_dut();
    rst         = 1'b1;
    Flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    InstrReady  = 1'b0;
    PC          = '0;
    mem_q.delete();
    exp_q.delete();
    prev_flush  = 1'b0;
    flush_on_rv = 1'b0;
    check_sat   = 1'b0;
    want_first  = 1'b0;
    @(negedge CLK);
    #1;
    check("rst_valid", InstrValid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_adv", PCAdvance, 1'b0);
    check("rst_instr", Instr, 32'h0);
    check("rst_instrpc", InstrPC, 32'h0);
    @(negedge CLK);
    rst         = 1'b0;
    cyc         = 0;
    adv_cnt     = 0;
    first_acc   = -1;
    first_valid = -1;
    pc_reg      = 32'h0;
  endtask

  // Stop issuing and let everything in flight and queued reach decode.
  task automatic drain();
    gnt_en = 1'b0;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || mem_q.size() != 0); i++) step(1'b0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", InstrValid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    lat = 1; gnt_en = 1'b0; flush_pc = 32'h0; sat_seen = 1'b0;

    // Zero-wait memory, decode always ready: full throughput, 2-cycle latency.
    reset_dut();
    gnt_en = 1'b1; lat = 1; want_first = 1'b1;
    repeat (12) step(1'b0, 1'b1);
    check("tput_adv_cnt", adv_cnt, 12);
    check("first_latency", first_valid - first_acc, 2);
    check("first_pc", first_pc, 32'h0);
    drain();

    // Decode stalled from reset: queue fills to 4 and requests stop.
    reset_dut();
    gnt_en = 1'b1; lat = 1;
    repeat (10) step(1'b0, 1'b0);
    check("stall_accepts", adv_cnt, 4);
    check("stall_req_low", imem_req, 1'b0);
    check("stall_head_valid", InstrValid, 1'b1);
    check("stall_head_pc", InstrPC, 32'h0);
    drain();

    // Slow memory: outstanding saturates and PCAdvance drops meanwhile.
    reset_dut();
    gnt_en = 1'b1; lat = 3; check_sat = 1'b1; sat_seen = 1'b0;
    repeat (16) step(1'b0, 1'b1);
    check("sat_seen", sat_seen, 1'b1);
    check_sat = 1'b0;
    drain();

    // Flush with two queued and two in flight; redirect to 0x100.
    reset_dut();
    gnt_en = 1'b1; lat = 1;
    repeat (2) step(1'b0, 1'b0);
    lat = 6;
    repeat (2) step(1'b0, 1'b0);
    check("pre_flush_valid", InstrValid, 1'b1);
    check("pre_flush_req", imem_req, 1'b0);
    flush_pc = 32'h100; lat = 1; want_first = 1'b1;
    step(1'b1, 1'b0);
    repeat (14) step(1'b0, 1'b1);
    check("flush_first_pc", first_pc, 32'h100);
    drain();

    // Flush coinciding with a returning word and a ready decode.
    reset_dut();
    gnt_en = 1'b1; lat = 2;
    repeat (6) step(1'b0, 1'b1);
    flush_pc = 32'h300; flush_on_rv = 1'b1; want_first = 1'b1;
    repeat (14) step(1'b0, 1'b1);
    check("flush_rv_fired", flush_on_rv, 1'b0);
    check("flush_rv_first_pc", first_pc, 32'h300);
    drain();

    // Asynchronous reset mid-burst, then a clean restart at 0x200.
    reset_dut();
    gnt_en = 1'b1; lat = 1;
    repeat (5) step(1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", InstrValid, 1'b0);
    check("arst_req", imem_req, 1'b0);
    check("arst_adv", PCAdvance, 1'b0);
    check("arst_instr", Instr, 32'h0);
    check("arst_instrpc", InstrPC, 32'h0);
    imem_rvalid = 1'b0;
    mem_q.delete();
    exp_q.delete();
    prev_flush = 1'b0;
    pc_reg = 32'h200;
    @(negedge CLK);
    rst = 1'b0;
    want_first = 1'b1;
    repeat (8) step(1'b0, 1'b1);
    check("arst_first_pc", first_pc, 32'h200);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
